axi4_lite_slave_regfile: RTL and testbench



---
 rtl/axi4_lite_slave_regfile.sv | 178 +++++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regfile.sv
// axi4_lite_slave_regfile
// AXI4-Lite responder that maps master reads and writes onto a
// word-addressed register array. Out-of-range accesses are answered with
// DECERR, and an 8-bit saturating counter records each DECERR issued.
//
// Handshake: a transfer happens on a rising edge where VALID and READY are
// both high. READY is only raised in IDLE. bvalid/rvalid and their payload
// stay stable until the matching ready is seen.
//
// Build option: define AXI_SLV_WSTRB_EN to honour wstrb byte enables.
// Without it, wstrb is ignored and every in-range write updates the whole
// word.
//
// state_dbg_o exposes the FSM state (0 IDLE, 1 WRESP, 2 RDATA).
module axi4_lite_slave_regfile #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int DEPTH          = 16
) (
    input  logic                          aclk,
    input  logic                          reset_n,
    input  logic [ADDRESS_WIDTH-1:0]      awaddr,
    input  logic                          awvalid,
    output logic                          awready,
    input  logic [REG_DATA_WIDTH-1:0]     wdata,
    input  logic [REG_DATA_WIDTH/8-1:0]   wstrb,
    input  logic                          wvalid,
    output logic                          wready,
    output logic [1:0]                    bresp,
    output logic                          bvalid,
    input  logic                          bready,
    input  logic [ADDRESS_WIDTH-1:0]      araddr,
    input  logic                          arvalid,
    output logic                          arready,
    output logic [REG_DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                    rresp,
    output logic                          rvalid,
    input  logic                          rready,
    output logic [7:0]                    err_count,
    output logic [1:0]                    state_dbg_o
);

    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int STRB_W = REG_DATA_WIDTH / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRESP = 2'd1;
    localparam logic [1:0] S_RDATA = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Full-width limit so upper address bits are never silently dropped.
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(DEPTH);

    logic [1:0]                state_q, state_d;
    logic [REG_DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [1:0]                bresp_q, rresp_q;
    logic [REG_DATA_WIDTH-1:0] rdata_q;
    logic [7:0]                err_count_q;

    logic             wr_req, rd_req;
    logic             aw_in_range, ar_in_range;
    logic             err_evt;
    logic [IDX_W-1:0] aw_idx, ar_idx;

    assign aw_in_range = (awaddr < DEPTH_A);
    assign ar_in_range = (araddr < DEPTH_A);
    assign aw_idx      = awaddr[IDX_W-1:0];
    assign ar_idx      = araddr[IDX_W-1:0];

    // A write needs both address and data; it has priority over a read
    // presented in the same cycle. Gated by reset_n so no ready is seen
    // while reset is held.
    assign wr_req = reset_n && (state_q == S_IDLE) && awvalid && wvalid;
    assign rd_req = reset_n && (state_q == S_IDLE) && arvalid && !wr_req;

    assign awready = wr_req;
    assign wready  = wr_req;
    assign arready = rd_req;

    assign bvalid      = (state_q == S_WRESP);
    assign rvalid      = (state_q == S_RDATA);
    assign bresp       = bresp_q;
    assign rresp       = rresp_q;
    assign rdata       = rdata_q;
    assign err_count   = err_count_q;
    assign state_dbg_o = state_q;

    assign err_evt = (wr_req && !aw_in_range) || (rd_req && !ar_in_range);

`ifndef AXI_SLV_WSTRB_EN
    logic unused_wstrb;
    assign unused_wstrb = ^wstrb;
`endif

    // Next-state logic: leave IDLE on an accepted request, return on the
    // response handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    state_d = S_WRESP;
                end else if (rd_req) begin
                    state_d = S_RDATA;
                end
            end
            S_WRESP: begin
                if (bready) begin
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (rready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset drops any pending response immediately.
    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Register array: updated only by an accepted in-range write.
    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_req && aw_in_range) begin
`ifdef AXI_SLV_WSTRB_EN
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem_q[aw_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
`else
            mem_q[aw_idx] <= wdata;
`endif
        end
    end

    // Response payloads are captured at the request handshake and then
    // held untouched until the next request.
    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            bresp_q <= RESP_OKAY;
            rresp_q <= RESP_OKAY;
            rdata_q <= '0;
        end else begin
            if (wr_req) begin
                bresp_q <= aw_in_range ? RESP_OKAY : RESP_DECERR;
            end
            if (rd_req) begin
                rresp_q <= ar_in_range ? RESP_OKAY : RESP_DECERR;
                rdata_q <= ar_in_range ? mem_q[ar_idx] : '0;
            end
        end
    end

    // DECERR counter, sticks at 255.
    always_ff @(posedge aclk or negedge reset_n) begin
        if (!reset_n) begin
            err_count_q <= 8'd0;
        end else if (err_evt && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// tb_axi4_lite_slave_regfile
// Bench for axi4_lite_slave_regfile with the default 32/32/16 geometry.
// Expected responses come from a small register model and are queued when a
// request is driven, then popped when the response handshake happens.
// Honours AXI_SLV_WSTRB_EN in its model the same way the design build does.
module tb_axi4_lite_slave_regfile;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          aclk;
  logic          reset_n;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;
  logic [7:0]    err_count;
  logic [1:0]    state_dbg;

  axi4_lite_slave_regfile #(
    .ADDRESS_WIDTH  (AW),
    .REG_DATA_WIDTH (DW),
    .DEPTH          (DEPTH)
  ) dut (
    .aclk        (aclk),
    .reset_n     (reset_n),
    .awaddr      (awaddr),
    .awvalid     (awvalid),
    .awready     (awready),
    .wdata       (wdata),
    .wstrb       (wstrb),
    .wvalid      (wvalid),
    .wready      (wready),
    .bresp       (bresp),
    .bvalid      (bvalid),
    .bready      (bready),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .err_count   (err_count),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- scoreboard state ----------------
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [33:0] exp_q[$];          // {resp, data}
  logic [31:0] model_mem[DEPTH];
  int          model_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
    model_err = 0;
    exp_q.delete();
  endtask

  task automatic note_err();
    if (model_err < 255) model_err++;
  endtask

  task automatic pop_check(input string tag, input logic [1:0] got_resp,
                           input logic [31:0] got_data, input bit with_data);
    logic [33:0] e;
    if (exp_q.size() == 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL %s_sb_empty: got response 0x%0h expected none", tag, got_resp);
    end else begin
      e = exp_q.pop_front();
      check_val({tag, "_resp"}, {62'd0, got_resp}, {62'd0, e[33:32]});
      if (with_data) check_val({tag, "_data"}, {32'd0, got_data}, {32'd0, e[31:0]});
    end
  endtask

  // Model side of a write: update registers and queue the expected bresp.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr < DEPTH) begin
      for (int b = 0; b < 4; b++) begin
`ifdef AXI_SLV_WSTRB_EN
        if (strb[b]) model_mem[addr][8*b +: 8] = data[8*b +: 8];
`else
        model_mem[addr][8*b +: 8] = data[8*b +: 8];
`endif
      end
      exp_q.push_back({2'b00, 32'h0});
    end else begin
      exp_q.push_back({2'b11, 32'h0});
      note_err();
    end
  endtask

  task automatic model_read(input logic [31:0] addr);
    if (addr < DEPTH) begin
      exp_q.push_back({2'b00, model_mem[addr]});
    end else begin
      exp_q.push_back({2'b11, 32'h0});
      note_err();
    end
  endtask

  // ---------------- driver tasks ----------------
  // Write, then hold bready low for 'hold' cycles while a second request is
  // presented; nothing must be accepted until the response completes.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int hold);
    logic [1:0] b0;
    @(negedge aclk);
    awaddr  = addr;
    wdata   = data;
    wstrb   = strb;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    model_write(addr, data, strb);
    #1;
    check_val("wr_awready", {63'd0, awready}, 64'd1);
    check_val("wr_wready", {63'd0, wready}, 64'd1);
    @(posedge aclk);
    #1;
    check_val("wr_bvalid_n1", {63'd0, bvalid}, 64'd1);
    b0 = bresp;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      #1;
      check_val("wr_hold_bvalid", {63'd0, bvalid}, 64'd1);
      check_val("wr_hold_bresp", {62'd0, bresp}, {62'd0, b0});
      check_val("wr_hold_awready", {62'd0, awready, wready}, 64'd0);
    end
    @(negedge aclk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    #1;
    check_val("wr_bvalid", {63'd0, bvalid}, 64'd1);
    pop_check("wr", bresp, 32'h0, 1'b0);
    @(posedge aclk);
    #1;
    check_val("wr_bvalid_fall", {63'd0, bvalid}, 64'd0);
    check_val("wr_err_count", {56'd0, err_count}, 64'(model_err));
    bready = 1'b0;
  endtask

  task automatic start_read(input logic [31:0] addr);
    @(negedge aclk);
    araddr  = addr;
    arvalid = 1'b1;
    model_read(addr);
    #1;
    check_val("rd_arready", {63'd0, arready}, 64'd1);
    @(posedge aclk);
    #1;
    check_val("rd_rvalid_n1", {63'd0, rvalid}, 64'd1);
  endtask

  task automatic finish_read(input int hold);
    logic [31:0] d0;
    d0 = rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      #1;
      check_val("rd_hold_rvalid", {63'd0, rvalid}, 64'd1);
      check_val("rd_hold_rdata", {32'd0, rdata}, {32'd0, d0});
      check_val("rd_hold_arready", {63'd0, arready}, 64'd0);
    end
    @(negedge aclk);
    arvalid = 1'b0;
    rready  = 1'b1;
    #1;
    check_val("rd_rvalid", {63'd0, rvalid}, 64'd1);
    pop_check("rd", rresp, rdata, 1'b1);
    @(posedge aclk);
    #1;
    check_val("rd_rvalid_fall", {63'd0, rvalid}, 64'd0);
    check_val("rd_err_count", {56'd0, err_count}, 64'(model_err));
    rready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    start_read(addr);
    finish_read(hold);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_bvalid"}, {63'd0, bvalid}, 64'd0);
    check_val({tag, "_rvalid"}, {63'd0, rvalid}, 64'd0);
    check_val({tag, "_bresp"}, {62'd0, bresp}, 64'd0);
    check_val({tag, "_rresp"}, {62'd0, rresp}, 64'd0);
    check_val({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
    check_val({tag, "_err_count"}, {56'd0, err_count}, 64'd0);
    check_val({tag, "_readies"}, {61'd0, awready, wready, arready}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 4'hF; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    model_reset();

    // Reset with every request presented: nothing may be accepted.
    #3 reset_n = 1'b0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    check_reset_outputs("reset");
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    reset_n = 1'b1;

    // Basic write/read.
    do_write(32'd3, 32'hDEADBEEF, 4'hF, 0);
    do_read(32'd3, 0);

    // Out of range at DEPTH and with high address bits set; last valid address.
    do_write(32'd16, 32'h12345678, 4'hF, 0);
    do_read(32'd16, 0);
    do_write(32'h1000_0000, 32'hCAFEF00D, 4'hF, 0);
    do_read(32'h1000_0003, 0);
    do_read(32'd0, 0);
    do_write(32'd15, 32'h0F0F0F0F, 4'hF, 0);
    do_read(32'd15, 0);

    // Held responses.
    do_write(32'd4, 32'hA5A5_5A5A, 4'hF, 5);
    do_read(32'd4, 4);

    // Write and read presented together: write first, read right after B.
    @(negedge aclk);
    awaddr = 32'd5; wdata = 32'h0BAD_CAFE; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'd5; arvalid = 1'b1;
    model_write(32'd5, 32'h0BAD_CAFE, 4'hF);
    #1;
    check_val("col_awready", {63'd0, awready}, 64'd1);
    check_val("col_arready_blocked", {63'd0, arready}, 64'd0);
    @(posedge aclk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge aclk);
    bready = 1'b1;
    #1;
    check_val("col_arready_wresp", {63'd0, arready}, 64'd0);
    pop_check("col_wr", bresp, 32'h0, 1'b0);
    @(posedge aclk);
    #1;
    bready = 1'b0;
    model_read(32'd5);
    check_val("col_arready_idle", {63'd0, arready}, 64'd1);
    @(posedge aclk);
    #1;
    check_val("col_rvalid", {63'd0, rvalid}, 64'd1);
    finish_read(0);

    // Byte strobes.
    do_write(32'd7, 32'h11223344, 4'hF, 0);
    do_write(32'd7, 32'hAABBCCDD, 4'b0101, 0);
    do_read(32'd7, 0);
    do_write(32'd8, 32'h55667788, 4'hF, 0);
    do_write(32'd8, 32'hFFFFFFFF, 4'b0000, 0);
    do_read(32'd8, 0);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(32'($urandom_range(0, 20)), $urandom, 4'($urandom_range(0, 15)),
                 int'($urandom_range(0, 2)));
      else
        do_read(32'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
    end

    // Saturate the error counter.
    for (int i = 0; i < 260; i++) do_write(32'd16 + 32'(i), 32'h0, 4'hF, 0);
    check_val("err_sat", {56'd0, err_count}, 64'd255);

    // Reset while a read response is pending.
    do_write(32'd2, 32'h2222_2222, 4'hF, 0);
    start_read(32'd2);
    @(negedge aclk);
    reset_n = 1'b0;
    arvalid = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    model_reset();
    @(negedge aclk);
    reset_n = 1'b1;
    @(posedge aclk);
    #1;
    check_val("post_reset_rvalid", {63'd0, rvalid}, 64'd0);
    do_read(32'd0, 0);
    do_read(32'd2, 0);

    check_val("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
